vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview: Parametrised successor to the fixed 640x400 VGA sync generator. It produces hSync, vSync, pixel and line coordinates, and a display-enable signal for any raster, with configurable polarities. It adds an internal pixel-clock divider, a run/freeze enable, and single-cycle line and frame start strobes. It sits between the pixel clock domain and the pixel source / frame-buffer reader.

Parameters:
H_DT, 640, horizontal display pixels
H_FP, 16, horizontal front porch
H_SP, 96, horizontal sync pulse width
H_BP, 48, horizontal back porch
H_POL, 0, hSync active level
V_DT, 480, vertical display lines
V_FP, 10, vertical front porch
V_SP, 2, vertical sync pulse width
V_BP, 33, vertical back porch
V_POL, 0, vSync active level
H_CNT_W, 10, pixelCnt width; must hold H_DT+H_FP+H_SP+H_BP-1
V_CNT_W, 10, lineCnt width; must hold V_DT+V_FP+V_SP+V_BP-1
PIX_DIV, 1, clock cycles per pixel (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run when 1; freeze all state when 0
hSync  out  1  horizontal sync
vSync  out  1  vertical sync
pixelCnt  out  H_CNT_W  current pixel column
lineCnt  out  V_CNT_W  current line
videoOn  out  1  1 when inside the display region
pixTick  out  1  1-cycle strobe: counters advanced this cycle
lineStart  out  1  1-cycle strobe: pixelCnt just wrapped to 0
frameStart  out  1  1-cycle strobe: (pixelCnt,lineCnt) just wrapped to (0,0)

Behaviour:
- Totals: H_TOT = H_DT+H_FP+H_SP+H_BP; V_TOT likewise. Integer constants, compared at counter width.
- Reset (reset=0, asynchronous): divCnt=0, pixelCnt=0, lineCnt=0, hSync=~H_POL, vSync=~V_POL, videoOn=0, all strobes 0.
- Divider: divCnt counts 0..PIX_DIV-1 while enable=1. Internal tick = enable && divCnt==PIX_DIV-1. When PIX_DIV=1, tick = enable.
- On tick, pixelCnt increments. At H_TOT-1 it wraps to 0 and lineCnt increments. lineCnt wraps to 0 when at V_TOT-1 and pixelCnt wraps.
- All outputs are registered and updated on the tick edge from the next counter values, so they stay aligned with pixelCnt/lineCnt. Latency is 0 relative to the coordinates.
- hSync = H_POL while the new pixelCnt is in [H_DT+H_FP, H_DT+H_FP+H_SP-1]; otherwise ~H_POL.
- vSync = V_POL while the new lineCnt is in [V_DT+V_FP, V_DT+V_FP+V_SP-1]; otherwise ~V_POL. vSync changes only on ticks where pixelCnt wraps to 0.
- videoOn = (new pixelCnt < H_DT) && (new lineCnt < V_DT). It is 0 from reset until the first tick.
- pixTick = registered tick.
- lineStart = 1 for exactly one clock, in the cycle after a tick that wrapped pixelCnt to 0.
- frameStart = 1 for exactly one clock, in the cycle after a tick that wrapped both counters to 0. It is not asserted on exit from reset.
- enable=0: divCnt, counters, hSync, vSync and videoOn hold their values; strobes are 0. Resuming continues from the held divCnt with no skipped or duplicated pixel.
- Reset asserted mid-frame returns to the reset state immediately, without waiting for a clock. After release, counting restarts from (0,0).
- Counters never exceed H_TOT-1 / V_TOT-1. Parameter sets violating the width rules fail an elaboration-time check.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60, 640x400@70 and 800x600@60;
  - a polarity-bit constant pair.
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical). Parameters: DT, FP, SP, BP, POL, W. Inputs: step. Outputs: cnt, wrap, sync_next, active_next.
- The top level holds the divider, the output registers and the strobe logic.

Test Plan:
1. Defaults, enable=1: sampled after cycle N. pixelCnt 655 -> hSync=1; 656 -> hSync=0; 751 -> 0; 752 -> 1; 640 -> videoOn=0; 799 -> 0 with lineCnt+1 and lineStart=1 for one cycle.
2. Defaults, full frame: lineCnt 490 -> vSync=0; 492 -> vSync=1. Wrap at (799,524) -> (0,0) with frameStart=1 for one cycle. Exactly 420000 clocks between frameStart pulses.
3. PIX_DIV=2 run -> pixelCnt advances every 2nd clock and pixTick toggles 0/1. Frame period is 840000 clocks. Strobe widths stay 1 clock.
4. enable=0 for 7 clocks at pixelCnt=100 -> all coordinates and syncs frozen, strobes 0. After release the next tick gives pixelCnt=101.
5. reset=0 asserted asynchronously mid-line at (300,200) -> outputs reach reset values before the next clock edge. After release the count restarts at 0 and no frameStart occurs until the first wrap.
6. Tiny raster (H 4/1/2/1, V 3/1/1/1, H_POL=1, V_POL=1, widths 3) -> exact waveform match against a reference model over 3 frames. hSync high at pixels 5-6; vSync high at line 4.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster timing constants for the VGA timing generator
package vga_timing_pkg;

  // Sync polarity: the level driven while the sync pulse is active
  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;

  // 640x480 @ 60 Hz
  localparam int VGA480_H_DT = 640;
  localparam int VGA480_H_FP = 16;
  localparam int VGA480_H_SP = 96;
  localparam int VGA480_H_BP = 48;
  localparam logic VGA480_H_POL = POL_NEG;
  localparam int VGA480_V_DT = 480;
  localparam int VGA480_V_FP = 10;
  localparam int VGA480_V_SP = 2;
  localparam int VGA480_V_BP = 33;
  localparam logic VGA480_V_POL = POL_NEG;

  // 640x400 @ 70 Hz
  localparam int VGA400_H_DT = 640;
  localparam int VGA400_H_FP = 16;
  localparam int VGA400_H_SP = 96;
  localparam int VGA400_H_BP = 48;
  localparam logic VGA400_H_POL = POL_NEG;
  localparam int VGA400_V_DT = 400;
  localparam int VGA400_V_FP = 12;
  localparam int VGA400_V_SP = 2;
  localparam int VGA400_V_BP = 35;
  localparam logic VGA400_V_POL = POL_POS;

  // 800x600 @ 60 Hz
  localparam int SVGA600_H_DT = 800;
  localparam int SVGA600_H_FP = 40;
  localparam int SVGA600_H_SP = 128;
  localparam int SVGA600_H_BP = 88;
  localparam logic SVGA600_H_POL = POL_POS;
  localparam int SVGA600_V_DT = 600;
  localparam int SVGA600_V_FP = 1;
  localparam int SVGA600_V_SP = 4;
  localparam int SVGA600_V_BP = 23;
  localparam logic SVGA600_V_POL = POL_POS;

  // Length of one axis in counter steps
  function automatic int axisTotal(int dt, int fp, int sp, int bp);
    return dt + fp + sp + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter plus look-ahead sync/active decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   DT  = 640,
  parameter int   FP  = 16,
  parameter int   SP  = 96,
  parameter int   BP  = 48,
  parameter logic POL = POL_NEG,
  parameter int   W   = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync_next,
  output logic         active_next
);

  localparam int TOT = axisTotal(DT, FP, SP, BP);
  localparam logic [W-1:0] LAST     = W'(TOT - 1);
  localparam logic [W-1:0] SYNC_LO  = W'(DT + FP);
  localparam logic [W-1:0] SYNC_HI  = W'(DT + FP + SP - 1);
  localparam logic [W-1:0] DISP_END = W'(DT);

  if (TOT - 1 >= (1 << W)) begin : gWidthCheck
    $error("vga_axis_counter: W=%0d cannot hold %0d", W, TOT - 1);
  end

  logic [W-1:0] cntNext;

  // wrap flags that the current position is the last one, so a step returns to 0
  assign wrap = (cnt == LAST);

  // Position the counter will hold after this cycle; decodes look at it so outputs stay aligned
  always_comb begin
    cntNext = cnt;
    if (step) begin
      cntNext = wrap ? '0 : cnt + 1'b1;
    end
  end

  assign sync_next   = (cntNext >= SYNC_LO && cntNext <= SYNC_HI) ? POL : ~POL;
  assign active_next = (cntNext < DISP_END);

  // Position register, advanced only on step
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cntNext;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync/coordinate generator with pixel divider and strobes
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DT    = VGA480_H_DT,
  parameter int   H_FP    = VGA480_H_FP,
  parameter int   H_SP    = VGA480_H_SP,
  parameter int   H_BP    = VGA480_H_BP,
  parameter logic H_POL   = VGA480_H_POL,
  parameter int   V_DT    = VGA480_V_DT,
  parameter int   V_FP    = VGA480_V_FP,
  parameter int   V_SP    = VGA480_V_SP,
  parameter int   V_BP    = VGA480_V_BP,
  parameter logic V_POL   = VGA480_V_POL,
  parameter int   H_CNT_W = 10,
  parameter int   V_CNT_W = 10,
  parameter int   PIX_DIV = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic               hSync,
  output logic               vSync,
  output logic [H_CNT_W-1:0] pixelCnt,
  output logic [V_CNT_W-1:0] lineCnt,
  output logic               videoOn,
  output logic               pixTick,
  output logic               lineStart,
  output logic               frameStart
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  if (PIX_DIV < 1) begin : gDivCheck
    $error("vga_timing_gen: PIX_DIV must be at least 1");
  end

  logic [DIV_W-1:0] divCnt;
  logic             tick;
  logic             hWrap, vWrap;
  logic             hSyncNext, vSyncNext;
  logic             hActiveNext, vActiveNext;

  assign tick = enable && (divCnt == DIV_LAST);

  // Pixel divider: free-runs while enabled, holds its phase while frozen
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divCnt <= '0;
    end else if (enable) begin
      divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
    end
  end

  vga_axis_counter #(
    .DT(H_DT), .FP(H_FP), .SP(H_SP), .BP(H_BP), .POL(H_POL), .W(H_CNT_W)
  ) hAxis (
    .clock      (clock),
    .reset      (reset),
    .step       (tick),
    .cnt        (pixelCnt),
    .wrap       (hWrap),
    .sync_next  (hSyncNext),
    .active_next(hActiveNext)
  );

  // The vertical axis only moves when the horizontal one wraps, so vSync changes at line boundaries
  vga_axis_counter #(
    .DT(V_DT), .FP(V_FP), .SP(V_SP), .BP(V_BP), .POL(V_POL), .W(V_CNT_W)
  ) vAxis (
    .clock      (clock),
    .reset      (reset),
    .step       (tick && hWrap),
    .cnt        (lineCnt),
    .wrap       (vWrap),
    .sync_next  (vSyncNext),
    .active_next(vActiveNext)
  );

  // Registered syncs, display enable and one-cycle strobes, refreshed on each pixel tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hSync      <= ~H_POL;
      vSync      <= ~V_POL;
      videoOn    <= 1'b0;
      pixTick    <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      pixTick    <= tick;
      lineStart  <= tick && hWrap;
      frameStart <= tick && hWrap && vWrap;
      if (tick) begin
        hSync   <= hSyncNext;
        vSync   <= vSyncNext;
        videoOn <= hActiveNext && vActiveNext;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default, tiny and divided rasters)
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  always #5 clock = ~clock;

  int nChecks = 0;
  int nFail = 0;

  // Instance 0: 640x480 defaults; 1: tiny raster, positive pols; 2: tiny raster, negative pols, divide by 2
  int mHDT[3] = '{640, 4, 4};
  int mHFP[3] = '{16, 1, 1};
  int mHSP[3] = '{96, 2, 2};
  int mHBP[3] = '{48, 1, 1};
  bit mHPOL[3] = '{1'b0, 1'b1, 1'b0};
  int mVDT[3] = '{480, 3, 3};
  int mVFP[3] = '{10, 1, 1};
  int mVSP[3] = '{2, 1, 1};
  int mVBP[3] = '{33, 1, 1};
  bit mVPOL[3] = '{1'b0, 1'b1, 1'b0};
  int mDIV[3] = '{1, 1, 2};

  logic [9:0] pxA, lnA;
  logic [2:0] pxB, lnB, pxC, lnC;
  logic hsA, vsA, vonA, ptA, lsA, fsA;
  logic hsB, vsB, vonB, ptB, lsB, fsB;
  logic hsC, vsC, vonC, ptC, lsC, fsC;

  vga_timing_gen dutA (
    .clock(clock), .reset(reset), .enable(enable),
    .hSync(hsA), .vSync(vsA), .pixelCnt(pxA), .lineCnt(lnA),
    .videoOn(vonA), .pixTick(ptA), .lineStart(lsA), .frameStart(fsA)
  );

  vga_timing_gen #(
    .H_DT(4), .H_FP(1), .H_SP(2), .H_BP(1), .H_POL(1'b1),
    .V_DT(3), .V_FP(1), .V_SP(1), .V_BP(1), .V_POL(1'b1),
    .H_CNT_W(3), .V_CNT_W(3), .PIX_DIV(1)
  ) dutB (
    .clock(clock), .reset(reset), .enable(enable),
    .hSync(hsB), .vSync(vsB), .pixelCnt(pxB), .lineCnt(lnB),
    .videoOn(vonB), .pixTick(ptB), .lineStart(lsB), .frameStart(fsB)
  );

  vga_timing_gen #(
    .H_DT(4), .H_FP(1), .H_SP(2), .H_BP(1), .H_POL(1'b0),
    .V_DT(3), .V_FP(1), .V_SP(1), .V_BP(1), .V_POL(1'b0),
    .H_CNT_W(3), .V_CNT_W(3), .PIX_DIV(2)
  ) dutC (
    .clock(clock), .reset(reset), .enable(enable),
    .hSync(hsC), .vSync(vsC), .pixelCnt(pxC), .lineCnt(lnC),
    .videoOn(vonC), .pixTick(ptC), .lineStart(lsC), .frameStart(fsC)
  );

  int obsPx[3], obsLn[3];
  bit obsHs[3], obsVs[3], obsVon[3], obsPt[3], obsLs[3], obsFs[3];

  always_comb begin
    obsPx[0] = int'(pxA); obsLn[0] = int'(lnA);
    obsPx[1] = int'(pxB); obsLn[1] = int'(lnB);
    obsPx[2] = int'(pxC); obsLn[2] = int'(lnC);
    obsHs[0] = hsA; obsVs[0] = vsA; obsVon[0] = vonA; obsPt[0] = ptA; obsLs[0] = lsA; obsFs[0] = fsA;
    obsHs[1] = hsB; obsVs[1] = vsB; obsVon[1] = vonB; obsPt[1] = ptB; obsLs[1] = lsB; obsFs[1] = fsB;
    obsHs[2] = hsC; obsVs[2] = vsC; obsVon[2] = vonC; obsPt[2] = ptC; obsLs[2] = lsC; obsFs[2] = fsC;
  end

  task automatic chk(string name, int idx, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // Reference model: count enabled clocks and pixel ticks, derive everything by arithmetic
  longint mEn[3];
  longint mK[3];
  bit mTick[3];

  task automatic modelCheck(int i);
    int hT, vT, ePx, eLn, hsLo, vsLo;
    bit eHs, eVs, eVon, eLs, eFs;
    hT = mHDT[i] + mHFP[i] + mHSP[i] + mHBP[i];
    vT = mVDT[i] + mVFP[i] + mVSP[i] + mVBP[i];
    ePx = int'(mK[i] % hT);
    eLn = int'((mK[i] / hT) % vT);
    hsLo = mHDT[i] + mHFP[i];
    vsLo = mVDT[i] + mVFP[i];
    eHs = (ePx >= hsLo && ePx < hsLo + mHSP[i]) ? mHPOL[i] : !mHPOL[i];
    eVs = (eLn >= vsLo && eLn < vsLo + mVSP[i]) ? mVPOL[i] : !mVPOL[i];
    eVon = (mK[i] > 0) && (ePx < mHDT[i]) && (eLn < mVDT[i]);
    eLs = mTick[i] && (ePx == 0);
    eFs = eLs && (eLn == 0);
    chk("model_pixelCnt", i, obsPx[i], ePx);
    chk("model_lineCnt", i, obsLn[i], eLn);
    chk("model_hSync", i, int'(obsHs[i]), int'(eHs));
    chk("model_vSync", i, int'(obsVs[i]), int'(eVs));
    chk("model_videoOn", i, int'(obsVon[i]), int'(eVon));
    chk("model_pixTick", i, int'(obsPt[i]), int'(mTick[i]));
    chk("model_lineStart", i, int'(obsLs[i]), int'(eLs));
    chk("model_frameStart", i, int'(obsFs[i]), int'(eFs));
  endtask

  always @(posedge clock or negedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        mEn[i] = 0; mK[i] = 0; mTick[i] = 1'b0;
      end else begin
        mTick[i] = enable && ((mEn[i] % mDIV[i]) == mDIV[i] - 1);
        if (enable) mEn[i] = mEn[i] + 1;
        if (mTick[i]) mK[i] = mK[i] + 1;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) modelCheck(i);
  end

  typedef struct {
    int n;
    int px;
    int ln;
    bit hs;
    bit vs;
    bit von;
    bit ls;
  } vec_t;

  vec_t vecs[$];

  task automatic periodCheck(int i, int expClocks);
    int cnt;
    bit found;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clock); #2;
      if (obsFs[i]) found = 1'b1;
    end
    chk("frameStart_seen", i, int'(found), 1);
    cnt = 0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clock); #2;
      cnt++;
      if (cnt == 1) chk("frameStart_width", i, int'(obsFs[i]), 0);
      if (obsFs[i]) found = 1'b1;
    end
    chk("frame_period", i, cnt, expClocks);
  endtask

  initial begin
    int cyc, hold0, hold1, hold2, hold3, prevPx, lsCnt, fsCnt;
    bit found, prevPt;

    // n: clocks after reset release with enable=1; expected dutA outputs
    vecs.push_back('{1,    1,   0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{640,  640, 0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{655,  655, 0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{656,  656, 0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{751,  751, 0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{752,  752, 0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{799,  799, 0, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{801,  1,   1, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1600, 0,   2, 1'b1, 1'b1, 1'b1, 1'b1});

    repeat (3) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      chk("reset_pixelCnt", i, obsPx[i], 0);
      chk("reset_lineCnt", i, obsLn[i], 0);
      chk("reset_hSync", i, int'(obsHs[i]), int'(!mHPOL[i]));
      chk("reset_vSync", i, int'(obsVs[i]), int'(!mVPOL[i]));
      chk("reset_videoOn", i, int'(obsVon[i]), 0);
      chk("reset_frameStart", i, int'(obsFs[i]), 0);
    end

    reset = 1'b1;
    enable = 1'b1;
    cyc = 0;
    foreach (vecs[e]) begin
      repeat (vecs[e].n - cyc) @(posedge clock);
      cyc = vecs[e].n;
      #2;
      chk("vec_pixelCnt", e, int'(pxA), vecs[e].px);
      chk("vec_lineCnt", e, int'(lnA), vecs[e].ln);
      chk("vec_hSync", e, int'(hsA), int'(vecs[e].hs));
      chk("vec_vSync", e, int'(vsA), int'(vecs[e].vs));
      chk("vec_videoOn", e, int'(vonA), int'(vecs[e].von));
      chk("vec_lineStart", e, int'(lsA), int'(vecs[e].ls));
    end

    // Freeze at pixelCnt=100 for 7 clocks
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(posedge clock); #2;
      if (pxA == 10'd100) found = 1'b1;
    end
    chk("reach_px100", 0, int'(found), 1);
    @(negedge clock);
    enable = 1'b0;
    hold0 = int'(lnA); hold1 = int'(hsA); hold2 = int'(vsA); hold3 = int'(vonA);
    repeat (7) begin
      @(posedge clock); #2;
      chk("freeze_pixelCnt", 0, int'(pxA), 100);
      chk("freeze_lineCnt", 0, int'(lnA), hold0);
      chk("freeze_hSync", 0, int'(hsA), hold1);
      chk("freeze_vSync", 0, int'(vsA), hold2);
      chk("freeze_videoOn", 0, int'(vonA), hold3);
      chk("freeze_strobes", 0, int'({ptA, lsA, fsA}), 0);
    end
    @(negedge clock);
    enable = 1'b1;
    @(posedge clock); #2;
    chk("resume_pixelCnt", 0, int'(pxA), 101);
    chk("resume_pixTick", 0, int'(ptA), 1);

    // Divide-by-2 instance: pixTick alternates and pixelCnt moves only with it
    @(posedge clock); #2;
    prevPt = ptC; prevPx = int'(pxC);
    repeat (12) begin
      @(posedge clock); #2;
      chk("div2_toggle", 2, int'(ptC), int'(!prevPt));
      chk("div2_advance", 2, int'(int'(pxC) != prevPx), int'(ptC));
      prevPt = ptC; prevPx = int'(pxC);
    end

    // Asynchronous reset mid-line at (300,3)
    found = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      @(posedge clock); #2;
      if (pxA == 10'd300 && lnA == 10'd3) found = 1'b1;
    end
    chk("reach_300_3", 0, int'(found), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_pixelCnt", 0, int'(pxA), 0);
    chk("async_lineCnt", 0, int'(lnA), 0);
    chk("async_hSync", 0, int'(hsA), 1);
    chk("async_vSync", 0, int'(vsA), 1);
    chk("async_videoOn", 0, int'(vonA), 0);
    chk("async_strobes", 0, int'({ptA, lsA, fsA}), 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #2;
    chk("restart_pixelCnt", 0, int'(pxA), 1);
    lsCnt = 0; fsCnt = 0;
    repeat (900) begin
      @(posedge clock); #2;
      lsCnt += int'(lsA);
      fsCnt += int'(fsA);
    end
    chk("restart_lineStarts", 0, lsCnt, 1);
    chk("restart_frameStarts", 0, fsCnt, 0);

    // Random enable with occasional reset pulses, checked by the model every clock
    repeat (3000) begin
      @(negedge clock);
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        reset = 1'b1;
      end
    end

    @(negedge clock);
    reset = 1'b1;
    enable = 1'b1;
    periodCheck(1, 48);
    periodCheck(2, 96);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
